// File: rtl/idex_forward_stage_pkg.sv
// Shared definitions for the ID/EX register stage: default widths, the layout
// of the registered control bundle and the all-zero bubble constant.
package idex_forward_stage_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int REGBITS_DEF = 5;

  // Bit positions inside the registered control bundle
  localparam int CTRL_VALID     = 0;
  localparam int CTRL_REG_WRITE = 1;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_USE_IMM   = 4;
  localparam int CTRL_W         = 5;

  typedef logic [CTRL_W-1:0] idex_ctrl_t;

  // A bubble carries no valid bit and no side effects, so it can never
  // forward, write, or trigger a load-use stall.
  localparam idex_ctrl_t CTRL_BUBBLE = '0;

  function automatic idex_ctrl_t pack_ctrl(input logic valid,
                                           input logic reg_write,
                                           input logic mem_read,
                                           input logic mem_write,
                                           input logic use_imm);
    idex_ctrl_t c;
    c                 = CTRL_BUBBLE;
    c[CTRL_VALID]     = valid;
    c[CTRL_REG_WRITE] = reg_write;
    c[CTRL_MEM_READ]  = mem_read;
    c[CTRL_MEM_WRITE] = mem_write;
    c[CTRL_USE_IMM]   = use_imm;
    return c;
  endfunction

endpackage

// File: rtl/idex_forward_stage_fwd_mux.sv
// Operand forwarding mux: picks the freshest value for one registered source
// index from EX/MEM, then MEM/WB, falling back to the registered regfile value.
// Register index 0 is hard-wired zero and is never forwarded.
module idex_forward_stage_fwd_mux
  import idex_forward_stage_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic [REGBITS-1:0] idx_i,
  input  logic [WIDTH-1:0]   val_i,
  input  logic               exmem_we_i,
  input  logic [REGBITS-1:0] exmem_rd_i,
  input  logic [WIDTH-1:0]   exmem_val_i,
  input  logic               memwb_we_i,
  input  logic [REGBITS-1:0] memwb_rd_i,
  input  logic [WIDTH-1:0]   memwb_val_i,
  output logic [WIDTH-1:0]   sel_o
);

  logic hit_exmem;
  logic hit_memwb;

  // Priority select: the younger EX/MEM result wins over MEM/WB
  always_comb begin
    hit_exmem = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
    hit_memwb = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);
    if (hit_exmem)      sel_o = exmem_val_i;
    else if (hit_memwb) sel_o = memwb_val_i;
    else                sel_o = val_i;
  end

endmodule

// File: rtl/idex_forward_stage.sv
// ID/EX pipeline register with operand forwarding and hazard detection.
// Drives the ALU operand buses and opcode, and requests a PC / IF-ID stall.
// Build option IDEX_FORWARDING_EN: when defined, EX/MEM and MEM/WB results are
// forwarded and only load-use hazards stall; when undefined, operands come
// straight from the registered regfile reads and every RAW hazard stalls.
module idex_forward_stage
  import idex_forward_stage_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [WIDTH-1:0]   id_busa,
  input  logic [WIDTH-1:0]   id_busb,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic               id_use_imm,
  input  logic [1:0]         id_alu_ctrl,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               flush,
  input  logic               exmem_reg_write,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_result,
  output logic [WIDTH-1:0]   BussA,
  output logic [WIDTH-1:0]   BussB,
  output logic [1:0]         ALUControl,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [REGBITS-1:0] ex_rd,
  output logic [WIDTH-1:0]   ex_store_data,
  output logic               stall_id
);

  idex_ctrl_t         ctrl_q,  ctrl_d;
  logic [1:0]         alu_q,   alu_d;
  logic [REGBITS-1:0] rs_q,    rs_d;
  logic [REGBITS-1:0] rt_q,    rt_d;
  logic [REGBITS-1:0] rd_q,    rd_d;
  logic [WIDTH-1:0]   busa_q,  busa_d;
  logic [WIDTH-1:0]   busb_q,  busb_d;
  logic [WIDTH-1:0]   imm_q,   imm_d;

  logic               load_bubble;
  logic               rt_used;
  logic               ex_load;
  logic [WIDTH-1:0]   fwd_a;
  logic [WIDTH-1:0]   fwd_b;

  // True when the ID instruction reads a non-zero register that 'rd' writes.
  // rt only counts as a source when BussB does not take the immediate, or
  // when it supplies store data.
  function automatic logic raw_hit(input logic               we,
                                   input logic [REGBITS-1:0] rd,
                                   input logic [REGBITS-1:0] rs,
                                   input logic [REGBITS-1:0] rt,
                                   input logic               rt_src);
    return we && (rd != '0) && ((rs == rd) || (rt_src && (rt == rd)));
  endfunction

  assign ex_valid     = ctrl_q[CTRL_VALID];
  assign ex_reg_write = ctrl_q[CTRL_REG_WRITE];
  assign ex_mem_read  = ctrl_q[CTRL_MEM_READ];
  assign ex_mem_write = ctrl_q[CTRL_MEM_WRITE];
  assign ex_rd        = rd_q;
  assign ALUControl   = alu_q;

  assign rt_used = !id_use_imm || id_mem_write;
  assign ex_load = ex_valid && ex_mem_read;

`ifdef IDEX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: stall one cycle for it
  always_comb begin
    stall_id = id_valid && raw_hit(ex_load, rd_q, id_rs, id_rt, rt_used);
  end

  idex_forward_stage_fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_rs (
    .idx_i       (rs_q),
    .val_i       (busa_q),
    .exmem_we_i  (exmem_reg_write),
    .exmem_rd_i  (exmem_rd),
    .exmem_val_i (exmem_result),
    .memwb_we_i  (memwb_reg_write),
    .memwb_rd_i  (memwb_rd),
    .memwb_val_i (memwb_result),
    .sel_o       (fwd_a)
  );

  idex_forward_stage_fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_rt (
    .idx_i       (rt_q),
    .val_i       (busb_q),
    .exmem_we_i  (exmem_reg_write),
    .exmem_rd_i  (exmem_rd),
    .exmem_val_i (exmem_result),
    .memwb_we_i  (memwb_reg_write),
    .memwb_rd_i  (memwb_rd),
    .memwb_val_i (memwb_result),
    .sel_o       (fwd_b)
  );
`else
  logic unused_fwd;

  // Without forwarding, any in-flight writer of a source register stalls ID
  always_comb begin
    stall_id = id_valid &&
               (raw_hit(ex_load,         rd_q,     id_rs, id_rt, rt_used) ||
                raw_hit(ex_reg_write,    rd_q,     id_rs, id_rt, rt_used) ||
                raw_hit(exmem_reg_write, exmem_rd, id_rs, id_rt, rt_used) ||
                raw_hit(memwb_reg_write, memwb_rd, id_rs, id_rt, rt_used));
  end

  assign fwd_a      = busa_q;
  assign fwd_b      = busb_q;
  assign unused_fwd = ^{rs_q, rt_q, exmem_result, memwb_result};
`endif

  assign BussA         = fwd_a;
  assign BussB         = ctrl_q[CTRL_USE_IMM] ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;

  // Next-state: capture ID, or insert a bubble on flush, stall or empty ID
  always_comb begin
    load_bubble = flush || stall_id || !id_valid;
    ctrl_d      = CTRL_BUBBLE;
    alu_d       = '0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    busa_d      = '0;
    busb_d      = '0;
    imm_d       = '0;
    if (!load_bubble) begin
      ctrl_d = pack_ctrl(1'b1, id_reg_write, id_mem_read, id_mem_write, id_use_imm);
      alu_d  = id_alu_ctrl;
      rs_d   = id_rs;
      rt_d   = id_rt;
      rd_d   = id_rd;
      busa_d = id_busa;
      busb_d = id_busb;
      imm_d  = id_imm;
    end
  end

  // The single ID/EX register; reset clears every field so nothing forwards
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_BUBBLE;
      alu_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      busa_q <= '0;
      busb_q <= '0;
      imm_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      busa_q <= busa_d;
      busb_q <= busb_d;
      imm_q  <= imm_d;
    end
  end

endmodule

// File: tb/tb_idex_forward_stage.sv
// Scoreboard bench for idex_forward_stage. Each cycle the driver sets inputs
// and queues the outputs expected at that cycle's falling edge; a separate
// monitor pops and compares at every falling edge.
module tb_idex_forward_stage;

`ifdef IDEX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_busa, id_busb, id_imm;
  logic        id_use_imm;
  logic [1:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] BussA, BussB, ex_store_data;
  logic [1:0]  ALUControl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        stall_id;

  // stand-alone forwarding mux
  logic [4:0]  fm_idx, fm_xrd, fm_wrd;
  logic [31:0] fm_val, fm_xv, fm_wv, fm_out;
  logic        fm_xw, fm_ww;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idex_forward_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_busa(id_busa), .id_busb(id_busb), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .BussA(BussA), .BussB(BussB), .ALUControl(ALUControl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .stall_id(stall_id)
  );

  idex_forward_stage_fwd_mux #(.WIDTH(32), .REGBITS(5)) u_mux (
    .idx_i(fm_idx), .val_i(fm_val),
    .exmem_we_i(fm_xw), .exmem_rd_i(fm_xrd), .exmem_val_i(fm_xv),
    .memwb_we_i(fm_ww), .memwb_rd_i(fm_wrd), .memwb_val_i(fm_wv),
    .sel_o(fm_out)
  );

  typedef struct {
    string       nm;
    logic        ev, rw, mr, mw;
    logic [1:0]  alu;
    logic [4:0]  rd;
    logic [31:0] a, b, sd;
    logic        st;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s got 0x%0h want 0x%0h", nm, f, act, exp);
    end
  endtask

  task automatic expect_c(input string nm, input logic ev, input logic rw, input logic mr,
                          input logic mw, input logic [1:0] alu, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                          input logic st);
    exp_t e;
    e.nm = nm; e.ev = ev; e.rw = rw; e.mr = mr; e.mw = mw; e.alu = alu;
    e.rd = rd; e.a = a; e.b = b; e.sd = sd; e.st = st;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input string nm, input logic st);
    expect_c(nm, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, st);
  endtask

  // monitor: compare at every falling edge, away from the capturing edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "ex_valid",      32'(ex_valid),      32'(e.ev));
      chk(e.nm, "ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
      chk(e.nm, "ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
      chk(e.nm, "ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
      chk(e.nm, "ALUControl",    32'(ALUControl),    32'(e.alu));
      chk(e.nm, "ex_rd",         32'(ex_rd),         32'(e.rd));
      chk(e.nm, "BussA",         BussA,              e.a);
      chk(e.nm, "BussB",         BussB,              e.b);
      chk(e.nm, "ex_store_data", ex_store_data,      e.sd);
      chk(e.nm, "stall_id",      32'(stall_id),      32'(e.st));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic ui, input logic [1:0] alu,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_busa = a; id_busb = b; id_imm = imm; id_use_imm = ui;
    id_alu_ctrl = alu; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic id_clear();
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw r5, 4(r1)
  task automatic id_lw();
    id_set(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
    id_set(1'b1, rs, rt, rd, a, b, 32'h0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fwd_set(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    exmem_reg_write = xw; exmem_rd = xrd; exmem_result = xres;
    memwb_reg_write = ww; memwb_rd = wrd; memwb_result = wres;
  endtask

  task automatic fwd_idle();
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic mux_chk(input string nm, input logic [4:0] idx, input logic [31:0] val,
                         input logic xw, input logic [4:0] xrd, input logic [31:0] xv,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wv,
                         input logic [31:0] exp);
    fm_idx = idx; fm_val = val; fm_xw = xw; fm_xrd = xrd; fm_xv = xv;
    fm_ww = ww; fm_wrd = wrd; fm_wv = wv;
    #1;
    chk(nm, "sel", fm_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    id_clear(); fwd_idle();
    fm_idx = '0; fm_val = '0; fm_xw = 1'b0; fm_xrd = '0; fm_xv = '0;
    fm_ww = 1'b0; fm_wrd = '0; fm_wv = '0;

    // reset held two cycles with a valid ID instruction
    tick(); reset = 1'b1; id_add(5'd1, 5'd2, 5'd6, 32'h5, 32'h6);
    expect_zero("reset_c0", 1'b0);
    tick();
    expect_zero("reset_c1", 1'b0);
    tick(); reset = 1'b0; id_add(5'd3, 5'd4, 5'd6, 32'h30, 32'h40);
    expect_zero("reset_out", 1'b0);

    // add in EX, both later stages write r3: EX/MEM must win
    tick(); id_clear(); fwd_set(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    expect_c("fwd_prio", 1, 1, 0, 0, 2'd2, 5'd6, FWD ? 32'h11 : 32'h30, 32'h40, 32'h40, 1'b0);

    tick(); id_add(5'd3, 5'd4, 5'd6, 32'h30, 32'h40); fwd_idle();
    expect_zero("bubble_idle", 1'b0);
    tick(); id_clear(); fwd_set(1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    expect_c("fwd_memwb", 1, 1, 0, 0, 2'd2, 5'd6, FWD ? 32'h22 : 32'h30, 32'h40, 32'h40, 1'b0);

    // index zero is never forwarded
    tick(); id_add(5'd0, 5'd4, 5'd6, 32'h0, 32'h40); fwd_idle();
    expect_zero("idx0_pre", 1'b0);
    tick(); id_clear(); fwd_set(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    expect_c("idx_zero", 1, 1, 0, 0, 2'd2, 5'd6, 32'h0, 32'h40, 32'h40, 1'b0);

    // load-use: lw r5 then add r8 = r5 + r2
    tick(); id_lw(); fwd_idle();
    expect_zero("lw_issue", 1'b0);
    tick(); id_add(5'd5, 5'd2, 5'd8, 32'h777, 32'h20);
    expect_c("loaduse_stall", 1, 1, 1, 0, 2'd0, 5'd5, 32'h100, 32'h4, 32'h0, 1'b1);
`ifdef IDEX_FORWARDING_EN
    tick(); fwd_set(1'b1, 5'd5, 32'h9999, 1'b0, 5'd0, 32'h0);
    expect_zero("loaduse_bubble", 1'b0);
    tick(); id_clear(); fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    expect_c("loaduse_fwd", 1, 1, 0, 0, 2'd2, 5'd8, 32'h1234, 32'h20, 32'h20, 1'b0);
`else
    tick(); fwd_set(1'b1, 5'd5, 32'h9999, 1'b0, 5'd0, 32'h0);
    expect_zero("raw_exmem", 1'b1);
    tick(); fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    expect_zero("raw_memwb", 1'b1);
    tick(); id_add(5'd5, 5'd2, 5'd8, 32'h1234, 32'h20); fwd_idle();
    expect_zero("raw_clear", 1'b0);
    tick(); id_clear();
    expect_c("raw_release", 1, 1, 0, 0, 2'd2, 5'd8, 32'h1234, 32'h20, 32'h20, 1'b0);
`endif

    // flush squashes a valid sub
    tick(); id_set(1'b1, 5'd9, 5'd10, 5'd11, 32'h90, 32'hA0, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; fwd_idle();
    expect_zero("flush_pre", 1'b0);
    tick(); id_clear(); flush = 1'b0;
    expect_zero("flush", 1'b0);

    // addi with rt=7 matching EX/MEM: rt is not a source, never stalls
    tick(); id_set(1'b1, 5'd2, 5'd7, 5'd9, 32'h200, 32'h70, 32'h8, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    fwd_set(1'b1, 5'd7, 32'hAB, 1'b0, 5'd0, 32'h0);
    expect_zero("addi_nostall", 1'b0);
    tick(); id_clear();
    expect_c("addi_imm", 1, 1, 0, 0, 2'd0, 5'd9, 32'h200, 32'h8, FWD ? 32'hAB : 32'h70, 1'b0);

    // sw with rt=7: store data forwarded, or stall without forwarding
    tick(); id_set(1'b1, 5'd2, 5'd7, 5'd0, 32'h200, 32'h70, 32'h8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    expect_zero("sw_issue", FWD ? 1'b0 : 1'b1);
    tick(); id_clear();
    if (FWD) expect_c("sw_store", 1, 0, 0, 1, 2'd0, 5'd0, 32'h200, 32'h8, 32'hAB, 1'b0);
    else     expect_zero("sw_store", 1'b0);

    // back-to-back ALU dependency: only stalls without forwarding
    tick(); id_add(5'd1, 5'd2, 5'd6, 32'h10, 32'h20); fwd_idle();
    expect_zero("dep_pre", 1'b0);
    tick(); id_add(5'd6, 5'd3, 5'd7, 32'h60, 32'h30);
    expect_c("dep_ex", 1, 1, 0, 0, 2'd2, 5'd6, 32'h10, 32'h20, 32'h20, FWD ? 1'b0 : 1'b1);
    tick(); id_clear();
    if (FWD) expect_c("dep_next", 1, 1, 0, 0, 2'd2, 5'd7, 32'h60, 32'h30, 32'h30, 1'b0);
    else     expect_zero("dep_next", 1'b0);

    // flush together with a load-use stall
    tick(); id_lw();
    expect_zero("fs_lw", 1'b0);
    tick(); id_add(5'd5, 5'd2, 5'd8, 32'h777, 32'h20); flush = 1'b1;
    expect_c("flush_stall", 1, 1, 1, 0, 2'd0, 5'd5, 32'h100, 32'h4, 32'h0, 1'b1);
    tick(); id_clear(); flush = 1'b0;
    expect_zero("flush_stall_out", 1'b0);

    // reset during a stall: stall drops once EX is cleared
    tick(); id_lw();
    expect_zero("rs_lw", 1'b0);
    tick(); id_add(5'd5, 5'd2, 5'd8, 32'h1234, 32'h20); reset = 1'b1;
    expect_c("reset_in_stall", 1, 1, 1, 0, 2'd0, 5'd5, 32'h100, 32'h4, 32'h0, 1'b1);
    tick(); reset = 1'b0;
    expect_zero("reset_drop", 1'b0);
    tick(); id_clear();
    expect_c("after_reset", 1, 1, 0, 0, 2'd2, 5'd8, 32'h1234, 32'h20, 32'h20, 1'b0);

    tick(); tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end

    // forwarding mux on its own
    mux_chk("mux_prio",  5'd3, 32'h30, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h11);
    mux_chk("mux_memwb", 5'd3, 32'h30, 1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h22);
    mux_chk("mux_zero",  5'd0, 32'h30, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h30);
    mux_chk("mux_miss",  5'd4, 32'h30, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h30);
    mux_chk("mux_exmem", 5'd4, 32'h30, 1'b1, 5'd4, 32'h44, 1'b0, 5'd4, 32'h55, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
